// File: rtl/rv523_shift_cell.sv
// Universal shift/count register: hold, shift, rotate, load and optional inc/dec.
// Define RV523_SHIFT_ARITH_EN to build the increment/decrement modes (100/101).

module rv523_shift_bit (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CE,
  input  logic [2:0] S,
  input  logic       shrIn,
  input  logic       shlIn,
  input  logic       rorIn,
  input  logic       rolIn,
  input  logic       d,
  input  logic       arith,
  output logic       q
);
  logic nxt;

  always_comb begin
    nxt = q;
    unique case (S)
      3'b000: nxt = q;
      3'b001: nxt = shrIn;
      3'b010: nxt = shlIn;
      3'b011: nxt = d;
      3'b100,
      3'b101: nxt = arith;
      3'b110: nxt = rorIn;
      3'b111: nxt = rolIn;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)     q <= 1'b0;
    else if (CE) q <= nxt;
  end
endmodule

module rv523_shift_cell #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CE,
  input  logic [2:0]       S,
  input  logic [WIDTH-1:0] D,
  input  logic             SR,
  input  logic             SL,
  output logic [WIDTH-1:0] Q,
  output logic             QR,
  output logic             QL,
  output logic             CO,
  output logic             ZERO
);
  logic [WIDTH-1:0] shrVec, shlVec, rorVec, rolVec, arithQ;
  logic             arithCo, coNxt;

  assign shrVec = {SR, Q[WIDTH-1:1]};
  assign shlVec = {Q[WIDTH-2:0], SL};
  assign rorVec = {Q[0], Q[WIDTH-1:1]};
  assign rolVec = {Q[WIDTH-2:0], Q[WIDTH-1]};

`ifdef RV523_SHIFT_ARITH_EN
  // S[0] picks decrement over increment; CO flags the wrap in either direction.
  assign arithQ  = S[0] ? (Q - 1'b1) : (Q + 1'b1);
  assign arithCo = S[0] ? (Q == '0) : (&Q);
`else
  assign arithQ  = Q;
  assign arithCo = 1'b0;
`endif

  for (genvar i = 0; i < WIDTH; i++) begin : gBit
    rv523_shift_bit uBit (
      .CLK   (CLK),
      .RST   (RST),
      .CE    (CE),
      .S     (S),
      .shrIn (shrVec[i]),
      .shlIn (shlVec[i]),
      .rorIn (rorVec[i]),
      .rolIn (rolVec[i]),
      .d     (D[i]),
      .arith (arithQ[i]),
      .q     (Q[i])
    );
  end

  always_comb begin
    coNxt = 1'b0;
    unique case (S)
      3'b001, 3'b110: coNxt = Q[0];
      3'b010, 3'b111: coNxt = Q[WIDTH-1];
      3'b100, 3'b101: coNxt = arithCo;
      default:        coNxt = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)     CO <= 1'b0;
    else if (CE) CO <= coNxt;
  end

  assign QR   = Q[0];
  assign QL   = Q[WIDTH-1];
  assign ZERO = (Q == '0);
endmodule

// File: tb/tb_rv523_shift_cell.sv
// Bench for rv523_shift_cell: directed vector table plus random run against an arithmetic model.
// Drives an 8-bit and a 4-bit instance from the same inputs.

module tb_rv523_shift_cell;
`ifdef RV523_SHIFT_ARITH_EN
  localparam bit ARITH = 1'b1;
`else
  localparam bit ARITH = 1'b0;
`endif

  logic       CLK = 1'b0, RST = 1'b1, ce = 1'b0, sl = 1'b0, sr = 1'b0;
  logic [2:0] s = 3'b000;
  logic [7:0] d = 8'h00;
  logic [7:0] q8;
  logic [3:0] q4;
  logic       qr8, ql8, co8, z8, qr4, ql4, co4, z4;

  int checks = 0, failures = 0;
  longint m8q = 0, m4q = 0;
  logic   m8co = 1'b0, m4co = 1'b0;

  rv523_shift_cell #(.WIDTH(8)) dut8 (
    .CLK(CLK), .RST(RST), .CE(ce), .S(s), .D(d), .SR(sr), .SL(sl),
    .Q(q8), .QR(qr8), .QL(ql8), .CO(co8), .ZERO(z8));

  rv523_shift_cell #(.WIDTH(4)) dut4 (
    .CLK(CLK), .RST(RST), .CE(ce), .S(s), .D(d[3:0]), .SR(sr), .SL(sl),
    .Q(q4), .QR(qr4), .QL(ql4), .CO(co4), .ZERO(z4));

  always #5 CLK = ~CLK;

  typedef struct {
    logic       ce;
    logic [2:0] s;
    logic [7:0] d;
    logic       sl, sr;
    logic [7:0] q;
    logic       co;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Register semantics written as plain integer arithmetic on a modulus of 2^w.
  function automatic void mstep(input int w, input longint q, input logic co,
                                input logic ce_, input logic [2:0] s_, input longint d_,
                                input logic sl_, input logic sr_,
                                output longint nq, output logic nco);
    longint m = longint'(1) << w;
    longint half = m / 2;
    nq = q; nco = co;
    if (!ce_) return;
    nco = 1'b0;
    case (s_)
      3'd1: begin nq = q / 2 + (sr_ ? half : 0); nco = (q % 2) == 1; end
      3'd2: begin nq = (q * 2 + longint'(sl_)) % m; nco = q >= half; end
      3'd3: nq = d_ % m;
      3'd4: if (ARITH) begin nq = (q + 1) % m; nco = (q == m - 1); end
      3'd5: if (ARITH) begin nq = (q + m - 1) % m; nco = (q == 0); end
      3'd6: begin nq = q / 2 + ((q % 2) == 1 ? half : 0); nco = (q % 2) == 1; end
      3'd7: begin nq = (q * 2) % m + (q >= half ? 1 : 0); nco = q >= half; end
      default: ;
    endcase
  endfunction

  task automatic step(input logic ce_, input logic [2:0] s_, input logic [7:0] d_,
                      input logic sl_, input logic sr_);
    longint n8, n4;
    logic c8, c4;
    ce = ce_; s = s_; d = d_; sl = sl_; sr = sr_;
    mstep(8, m8q, m8co, ce_, s_, longint'(d_), sl_, sr_, n8, c8);
    mstep(4, m4q, m4co, ce_, s_, longint'(d_), sl_, sr_, n4, c4);
    @(posedge CLK); #1;
    m8q = n8; m8co = c8; m4q = n4; m4co = c4;
  endtask

  task automatic chk8(input string tag, input longint eq, input logic eco);
    chk({tag, ".Q"},    longint'(q8),  eq);
    chk({tag, ".CO"},   longint'(co8), longint'(eco));
    chk({tag, ".ZERO"}, longint'(z8),  longint'(eq == 0));
    chk({tag, ".QR"},   longint'(qr8), eq % 2);
    chk({tag, ".QL"},   longint'(ql8), eq / 128);
  endtask

  task automatic chk4(input string tag);
    chk({tag, ".Q4"},    longint'(q4),  m4q);
    chk({tag, ".CO4"},   longint'(co4), longint'(m4co));
    chk({tag, ".ZERO4"}, longint'(z4),  longint'(m4q == 0));
    chk({tag, ".QL4"},   longint'(ql4), m4q / 8);
    chk({tag, ".QR4"},   longint'(qr4), m4q % 2);
  endtask

  // Async reset a few ns into the cycle, checked before any clock edge.
  task automatic midReset(input string tag);
    #2 RST = 1'b1;
    #1;
    chk8({tag, ".rst"}, 0, 1'b0);
    chk({tag, ".rst.Q4"}, longint'(q4), 0);
    chk({tag, ".rst.CO4"}, longint'(co4), 0);
    RST = 1'b0;
    m8q = 0; m8co = 1'b0; m4q = 0; m4co = 1'b0;
  endtask

  initial begin
    // Directed sequence; expected Q/CO written out by hand.
    tbl.push_back('{1'b1, 3'b011, 8'h81, 1'b0, 1'b0, 8'h81, 1'b0});
    tbl.push_back('{1'b1, 3'b001, 8'h00, 1'b1, 1'b0, 8'h40, 1'b1});
    tbl.push_back('{1'b1, 3'b010, 8'h00, 1'b1, 1'b0, 8'h81, 1'b0});
    tbl.push_back('{1'b1, 3'b010, 8'h00, 1'b1, 1'b1, 8'h03, 1'b1});
    tbl.push_back('{1'b1, 3'b011, 8'h01, 1'b0, 1'b0, 8'h01, 1'b0});
    tbl.push_back('{1'b1, 3'b110, 8'hFF, 1'b0, 1'b1, 8'h80, 1'b1});
    tbl.push_back('{1'b1, 3'b111, 8'h00, 1'b1, 1'b0, 8'h01, 1'b1});
    tbl.push_back('{1'b1, 3'b111, 8'h00, 1'b0, 1'b1, 8'h02, 1'b0});
    tbl.push_back('{1'b1, 3'b001, 8'h00, 1'b0, 1'b1, 8'h81, 1'b0});
    tbl.push_back('{1'b1, 3'b001, 8'h00, 1'b0, 1'b0, 8'h40, 1'b1});
    tbl.push_back('{1'b0, 3'b011, 8'h55, 1'b1, 1'b1, 8'h40, 1'b1});
    tbl.push_back('{1'b1, 3'b000, 8'h55, 1'b1, 1'b1, 8'h40, 1'b0});
    tbl.push_back('{1'b1, 3'b011, 8'hFE, 1'b0, 1'b0, 8'hFE, 1'b0});
    tbl.push_back('{1'b1, 3'b100, 8'h00, 1'b0, 1'b0, ARITH ? 8'hFF : 8'hFE, 1'b0});
    tbl.push_back('{1'b1, 3'b100, 8'h00, 1'b0, 1'b0, ARITH ? 8'h00 : 8'hFE, ARITH});
    tbl.push_back('{1'b1, 3'b101, 8'h00, 1'b0, 1'b0, ARITH ? 8'hFF : 8'hFE, ARITH});
    tbl.push_back('{1'b1, 3'b011, 8'h10, 1'b0, 1'b0, 8'h10, 1'b0});
    tbl.push_back('{1'b1, 3'b100, 8'h00, 1'b1, 1'b1, ARITH ? 8'h11 : 8'h10, 1'b0});
    tbl.push_back('{1'b1, 3'b100, 8'h00, 1'b1, 1'b1, ARITH ? 8'h12 : 8'h10, 1'b0});
    tbl.push_back('{1'b1, 3'b100, 8'h00, 1'b1, 1'b1, ARITH ? 8'h13 : 8'h10, 1'b0});
    tbl.push_back('{1'b1, 3'b011, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0});
    tbl.push_back('{1'b1, 3'b101, 8'h00, 1'b0, 1'b0, ARITH ? 8'hFF : 8'h00, ARITH});

    #12;
    chk8("reset", 0, 1'b0);
    RST = 1'b0;

    // Async reset after loading 0xA5, then hold keeps zero.
    step(1'b1, 3'b011, 8'hA5, 1'b0, 1'b0);
    chk8("loadA5", 8'hA5, 1'b0);
    midReset("midA5");
    step(1'b1, 3'b000, 8'hFF, 1'b1, 1'b1);
    chk8("postRstHold", 0, 1'b0);

    foreach (tbl[i]) begin
      step(tbl[i].ce, tbl[i].s, tbl[i].d, tbl[i].sl, tbl[i].sr);
      chk8($sformatf("vec%0d", i), longint'(tbl[i].q), tbl[i].co);
      chk4($sformatf("vec%0d", i));
    end

    // CE=0 freezes the 4-bit instance at 0x9 whatever the other inputs do.
    step(1'b1, 3'b011, 8'h09, 1'b0, 1'b0);
    chk({"w4load"}, longint'(q4), 9);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 3'($urandom_range(7)), 8'($urandom), 1'($urandom), 1'($urandom));
      chk($sformatf("w4ceOff%0d", i), longint'(q4), 9);
      chk($sformatf("w4ceOffCo%0d", i), longint'(co4), 0);
    end
    step(1'b1, 3'b011, 8'h0F, 1'b0, 1'b0);
    step(1'b1, 3'b100, 8'h00, 1'b0, 1'b0);
    chk("w4incQ", longint'(q4), ARITH ? 0 : 15);
    chk("w4incCo", longint'(co4), longint'(ARITH));
    chk4("w4inc");

    // Random traffic against the model, with occasional async resets.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(7) != 0), 3'($urandom_range(7)), 8'($urandom),
           1'($urandom), 1'($urandom));
      chk8($sformatf("rnd%0d", i), m8q, m8co);
      chk4($sformatf("rnd%0d", i));
      if ($urandom_range(39) == 0) midReset($sformatf("rndRst%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rv523_shift_cell.md
# rv523_shift_cell

Parametrised universal shift/count register for the RV523 cell library: WIDTH flip-flops with a shared next-state selector offering hold, shift, rotate, parallel load and (optionally) increment/decrement. It is the sequential companion to the combinational AOI/OAI cells and provides one library primitive for register-file staging, shifter stages and loop counters in the datapath. All state updates happen on the rising clock edge. Outputs come directly from the flops.

## Interface
- WIDTH, 8: register width in bits; legal values are 2..32.
- CLK  input  1  clock; rising edge active.
- RST  input  1  asynchronous, active-high reset.
- CE  input  1  clock enable; state changes only when CE=1.
- S  input  3  mode select (see Operation).
- D  input  WIDTH  parallel load data.
- SR  input  1  serial input for shift right; enters at the MSB.
- SL  input  1  serial input for shift left; enters at the LSB.
- Q  output  WIDTH  register contents.
- QR  output  1  equals Q[0]; serial output when shifting right.
- QL  output  1  equals Q[WIDTH-1]; serial output when shifting left.
- CO  output  1  registered carry/borrow flag.
- ZERO  output  1  combinational; high when Q == 0.

## Operation
- Mode decode of S, applied only when CE=1:
  - 000 hold.
  - 001 shift right: Q <= {SR, Q[WIDTH-1:1]}.
  - 010 shift left: Q <= {Q[WIDTH-2:0], SL}.
  - 011 load: Q <= D.
  - 100 increment: Q <= Q+1, modulo 2^WIDTH.
  - 101 decrement: Q <= Q-1, modulo 2^WIDTH.
  - 110 rotate right: Q <= {Q[0], Q[WIDTH-1:1]}.
  - 111 rotate left: Q <= {Q[WIDTH-2:0], Q[WIDTH-1]}.
- CO is updated on every CE=1 edge:
  - Increment: CO <= (Q was all ones).
  - Decrement: CO <= (Q was zero).
  - Shift right and rotate right: CO <= the old Q[0].
  - Shift left and rotate left: CO <= the old Q[WIDTH-1].
  - Load and hold: CO <= 0.
- CE=0: Q and CO hold, whatever S is.
- Wrap-around: increment from all ones gives 0 with CO=1. Decrement from 0 gives all ones with CO=1.
- SL and SR are ignored in every mode except 010 and 001 respectively.
- No internal state other than Q and CO. No illegal mode values exist.

## Timing
- Reset: while RST=1, Q=0 and CO=0, so ZERO=1, QL=0, QR=0. Reset takes effect asynchronously, with no clock required.
- Reset mid-operation: asserting RST clears state immediately. On the first rising edge after RST deasserts, normal mode decode applies.
- Latency: one cycle. Q, QL, QR and CO reflect the operation selected at edge n from edge n onward.
- ZERO follows Q combinationally, so it has the same timing as Q.
- S, D, SL, SR and CE are sampled only at the rising edge. They need no hold beyond the flop hold time.
- Back-to-back operations of any mode are legal every cycle. No handshake is required.

## Configuration
- RV523_SHIFT_ARITH_EN defined:
  - Modes 100 and 101 increment and decrement as above.
  - CO reports carry and borrow.
- RV523_SHIFT_ARITH_EN undefined:
  - Modes 100 and 101 behave exactly as hold, with CO <= 0 on CE=1.
  - No adder or subtractor logic is generated. All other modes are unchanged.

## Test plan
- Reset: drive RST=1 asynchronously mid-cycle after loading 0xA5 (WIDTH=8) -> Q=0x00, CO=0, ZERO=1 before the next edge. After release with S=000, Q stays 0x00.
- Load and shift: load 0x81, then shift right with SR=0 -> Q=0x40, CO=1. Then shift left twice with SL=1 -> 0x81, then 0x03, with CO=0 then CO=1.
- Rotate: load 0x01, rotate right -> Q=0x80, CO=1. Rotate left twice -> 0x01, then 0x02.
- Counter wrap (macro on): load 0xFE, increment twice -> 0xFF with CO=0, then 0x00 with CO=1 and ZERO=1. Decrement -> 0xFF, CO=1.
- Counter disabled (macro off): load 0x10, S=100 for 3 cycles -> Q stays 0x10, CO=0.
- Clock enable and width: with WIDTH=4 and CE=0, all modes and random D/SL/SR for 10 cycles leave Q=0x9 unchanged. With CE=1, increment from 0xF gives 0x0 with CO=1.
